// File: rtl/bit_entry_debouncer.sv
// Pushbutton/switch front end: synchronizes both raw inputs, debounces the button
// and emits one captured switch bit with a one-cycle strobe per accepted press.
// Optional macro HISTORY_EN adds an 8-bit shift register of accepted bits (bit 0 newest).
module bit_entry_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       btn_raw,
  input  logic       sw_raw,
  output logic       sig_to_test,
  output logic       sig_valid,
  output logic       btn_held
`ifdef HISTORY_EN
  ,
  output logic [7:0] history
`endif
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, RELEASE_DB} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
  logic [SYNC_STAGES-1:0] sw_sync_q, sw_sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   bit_q, bit_d;
  logic                   valid_q, valid_d;
  logic                   btn_s, sw_s, cnt_done;
`ifdef HISTORY_EN
  logic [7:0]             history_q, history_d;
`endif

  assign btn_s    = btn_sync_q[SYNC_STAGES-1];
  assign sw_s     = sw_sync_q[SYNC_STAGES-1];
  assign btn_sync_d = {btn_sync_q[SYNC_STAGES-2:0], btn_raw};
  assign sw_sync_d  = {sw_sync_q[SYNC_STAGES-2:0], sw_raw};
  // Compare with >= so the counter saturates instead of wrapping.
  assign cnt_done = (cnt_q >= CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      btn_sync_q <= '0;
      sw_sync_q  <= '0;
      cnt_q      <= '0;
      bit_q      <= 1'b0;
      valid_q    <= 1'b0;
`ifdef HISTORY_EN
      history_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      btn_sync_q <= btn_sync_d;
      sw_sync_q  <= sw_sync_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      valid_q    <= valid_d;
`ifdef HISTORY_EN
      history_q  <= history_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    valid_d = 1'b0;
    if (!ena) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_d = PRESS_DB;
            cnt_d   = '0;
          end
        end
        PRESS_DB: begin
          // A low sample wins even on the final count cycle.
          if (!btn_s) begin
            state_d = IDLE;
          end else if (cnt_done) begin
            state_d = PRESSED;
            bit_d   = sw_s;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state_d = RELEASE_DB;
            cnt_d   = '0;
          end
        end
        RELEASE_DB: begin
          if (btn_s) begin
            state_d = PRESSED;
          end else if (cnt_done) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef HISTORY_EN
  always_comb begin
    history_d = history_q;
    if (valid_d) history_d = {history_q[6:0], sw_s};
  end
`endif

  always_comb begin
    sig_to_test = bit_q;
    sig_valid   = valid_q;
    btn_held    = (state_q == PRESSED) || (state_q == RELEASE_DB);
`ifdef HISTORY_EN
    history     = history_q;
`endif
  end

endmodule
